// File: rtl/rib_timer.sv
// Purpose : memory-mapped 32-bit timer (RIB responder) with prescaler, compare match and level interrupt.
// Latency : reads are combinational (0 cycles); writes land on the rising edge ending the request cycle.
// Backpress: none; every request completes in one cycle and no stall is ever requested.
//
// Ports:
//   clk    - system clock (rising edge)
//   rst    - asynchronous active-low reset
//   req_i  - decoded bus request;  we_i - write strobe (valid with req_i)
//   addr_i - byte address, [3:2] selects CTRL/COUNT/CMP/reserved
//   data_i - write data;  data_o - read data (0 when not reading)
//   int_o  - level interrupt, PEND & IE
module rib_timer #(
    parameter int PS_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_o
);

    localparam logic [1:0] A_CTRL  = 2'd0;
    localparam logic [1:0] A_COUNT = 2'd1;
    localparam logic [1:0] A_CMP   = 2'd2;

    logic            r_en;
    logic            r_ie;
    logic            r_oneshot;
    logic            r_pend;
    logic [PS_W-1:0] r_prescale;
    logic [PS_W-1:0] r_ps_cnt;
    logic [31:0]     r_count;
    logic [31:0]     r_cmp;

    logic            w_ctrl_wr;
    logic            w_count_wr;
    logic            w_cmp_wr;
    logic            w_tick;
    logic            w_match;
    logic            w_en_nxt;
    logic            w_pend_nxt;
    logic [31:0]     w_ctrl_rd;

    // Only addr_i[3:2] is decoded; the remaining address bits are ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^{addr_i[31:4], addr_i[1:0]};

    assign w_ctrl_wr  = req_i & we_i & (addr_i[3:2] == A_CTRL);
    assign w_count_wr = req_i & we_i & (addr_i[3:2] == A_COUNT);
    assign w_cmp_wr   = req_i & we_i & (addr_i[3:2] == A_CMP);

    // A tick ends each prescaler period; a match is a tick that sees COUNT == CMP
    // (using the pre-write CMP and COUNT values of this cycle).
    assign w_tick  = r_en & (r_ps_cnt == r_prescale);
    assign w_match = w_tick & (r_count == r_cmp);

    // A bus write to EN overrides the one-shot auto-disable.
    always_comb begin
        w_en_nxt = r_en;
        if (w_ctrl_wr) begin
            w_en_nxt = data_i[0];
        end else if (w_match && r_oneshot) begin
            w_en_nxt = 1'b0;
        end
    end

    // Hardware set beats a simultaneous W1C.
    assign w_pend_nxt = w_match | (r_pend & ~(w_ctrl_wr & data_i[3]));

    always_comb begin
        w_ctrl_rd              = '0;
        w_ctrl_rd[0]           = r_en;
        w_ctrl_rd[1]           = r_ie;
        w_ctrl_rd[2]           = r_oneshot;
        w_ctrl_rd[3]           = r_pend;
        w_ctrl_rd[8 +: PS_W]   = r_prescale;
    end

    always_comb begin
        data_o = '0;
        if (req_i && !we_i) begin
            case (addr_i[3:2])
                A_CTRL:  data_o = w_ctrl_rd;
                A_COUNT: data_o = r_count;
                A_CMP:   data_o = r_cmp;
                default: data_o = '0;
            endcase
        end
    end

    assign int_o = r_pend & r_ie;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_oneshot  <= 1'b0;
            r_pend     <= 1'b0;
            r_prescale <= '0;
        end else begin
            r_en   <= w_en_nxt;
            r_pend <= w_pend_nxt;
            if (w_ctrl_wr) begin
                r_ie       <= data_i[1];
                r_oneshot  <= data_i[2];
                r_prescale <= data_i[8 +: PS_W];
            end
        end
    end

    // Prescaler sits at 0 whenever the timer is (or is about to be) disabled,
    // so an enabling write always starts a fresh period from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ps_cnt <= '0;
        end else if (!r_en || !w_en_nxt || w_tick) begin
            r_ps_cnt <= '0;
        end else begin
            r_ps_cnt <= r_ps_cnt + {{(PS_W-1){1'b0}}, 1'b1};
        end
    end

    // A bus write to COUNT drops the tick's update for that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_count_wr) begin
            r_count <= data_i;
        end else if (w_match) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= r_count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmp <= 32'hFFFF_FFFF;
        end else if (w_cmp_wr) begin
            r_cmp <= data_i;
        end
    end

endmodule

// File: tb/tb_rib_timer.sv
module tb_rib_timer;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        int_o;

    int tests;
    int fails;

    localparam logic [31:0] CTRL  = 32'h0;
    localparam logic [31:0] COUNT = 32'h4;
    localparam logic [31:0] CMP   = 32'h8;
    localparam logic [31:0] RSVD  = 32'hC;

    rib_timer #(.PS_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .int_o  (int_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Bus helpers: entered and left at a falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        req_i  = 1'b1;
        we_i   = 1'b1;
        addr_i = a;
        data_i = d;
        @(negedge clk);
        req_i  = 1'b0;
        we_i   = 1'b0;
        addr_i = '0;
        data_i = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = a;
        #1;
        d      = data_o;
        req_i  = 1'b0;
        addr_i = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        // reset held from time 0
        #1;
        tests++; if (int_o !== 1'b0) begin fails++; $display("FAIL reset_int0 got %0b want 0", int_o); end
        tests++; if (data_o !== 32'h0) begin fails++; $display("FAIL reset_data0 got %h want 0", data_o); end
        @(negedge clk);
        rst = 1'b1;
        // start counting, then reset mid-count
        wr(CMP, 32'h20);
        wr(CTRL, 32'h3);
        idle(3);
        rd(COUNT, v);
        tests++; if (v !== 32'h3) begin fails++; $display("FAIL pre_reset_count got %h want 3", v); end
        #2 rst = 1'b0;
        rd(CTRL, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_ctrl got %h want 0", v); end
        rd(COUNT, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_count got %h want 0", v); end
        rd(CMP, v);
        tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_cmp got %h want ffffffff", v); end
        tests++; if (int_o !== 1'b0) begin fails++; $display("FAIL reset_int got %0b want 0", int_o); end
        idle(2);
        rst = 1'b1;
        idle(3);
        rd(COUNT, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL post_reset_idle_count got %h want 0", v); end
        tests++; if (int_o !== 1'b0) begin fails++; $display("FAIL post_reset_int got %0b want 0", int_o); end
    endtask

    task automatic test_periodic;
        logic [31:0] v;
        logic [31:0] exp_cnt [4];
        exp_cnt[0] = 32'd1; exp_cnt[1] = 32'd2; exp_cnt[2] = 32'd3; exp_cnt[3] = 32'd0;
        wr(COUNT, 32'h0);
        wr(CMP, 32'h3);
        wr(CTRL, 32'h3);
        rd(CTRL, v);
        tests++; if (v !== 32'h3) begin fails++; $display("FAIL per_ctrl_start got %h want 3", v); end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            rd(COUNT, v);
            tests++; if (v !== exp_cnt[i]) begin fails++; $display("FAIL per_count[%0d] got %h want %h", i, v, exp_cnt[i]); end
        end
        rd(CTRL, v);
        tests++; if (v !== 32'hB) begin fails++; $display("FAIL per_pend_set got %h want b", v); end
        tests++; if (int_o !== 1'b1) begin fails++; $display("FAIL per_int got %0b want 1", int_o); end
        wr(CTRL, 32'hB);
        rd(CTRL, v);
        tests++; if (v !== 32'h3) begin fails++; $display("FAIL per_w1c got %h want 3", v); end
        tests++; if (int_o !== 1'b0) begin fails++; $display("FAIL per_int_fall got %0b want 0", int_o); end
        idle(2);
        rd(CTRL, v);
        tests++; if (v !== 32'h3) begin fails++; $display("FAIL per_pend_early got %h want 3", v); end
        idle(1);
        rd(CTRL, v);
        tests++; if (v !== 32'hB) begin fails++; $display("FAIL per_pend_second got %h want b", v); end
        wr(CTRL, 32'h8);
    endtask

    task automatic test_prescaler;
        logic [31:0] v;
        wr(COUNT, 32'h0);
        wr(CMP, 32'h1);
        wr(CTRL, 32'h0000_0403);
        idle(4);
        rd(COUNT, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL ps_count_before got %h want 0", v); end
        idle(1);
        rd(COUNT, v);
        tests++; if (v !== 32'h1) begin fails++; $display("FAIL ps_count_first got %h want 1", v); end
        idle(4);
        rd(CTRL, v);
        tests++; if (v !== 32'h0000_0403) begin fails++; $display("FAIL ps_pend_early got %h want 403", v); end
        idle(1);
        rd(CTRL, v);
        tests++; if (v !== 32'h0000_040B) begin fails++; $display("FAIL ps_pend_at10 got %h want 40b", v); end
        rd(COUNT, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL ps_count_wrap got %h want 0", v); end
        wr(CTRL, 32'h8);
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        wr(COUNT, 32'h0);
        wr(CMP, 32'h2);
        wr(CTRL, 32'h7);
        idle(2);
        rd(CTRL, v);
        tests++; if (v !== 32'h7) begin fails++; $display("FAIL os_before got %h want 7", v); end
        idle(1);
        rd(CTRL, v);
        tests++; if (v !== 32'hE) begin fails++; $display("FAIL os_match got %h want e", v); end
        tests++; if (int_o !== 1'b1) begin fails++; $display("FAIL os_int got %0b want 1", int_o); end
        idle(20);
        rd(COUNT, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL os_count_hold got %h want 0", v); end
        rd(CTRL, v);
        tests++; if (v !== 32'hE) begin fails++; $display("FAIL os_ctrl_hold got %h want e", v); end
        wr(CTRL, 32'h8);
        rd(CTRL, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL os_clear got %h want 0", v); end
    endtask

    task automatic test_collisions;
        logic [31:0] v;
        // W1C in the match-tick cycle
        wr(COUNT, 32'h0);
        wr(CMP, 32'h1);
        wr(CTRL, 32'h3);
        idle(1);
        rd(COUNT, v);
        tests++; if (v !== 32'h1) begin fails++; $display("FAIL col_pre_match got %h want 1", v); end
        wr(CTRL, 32'hB);
        rd(CTRL, v);
        tests++; if (v !== 32'hB) begin fails++; $display("FAIL col_w1c_vs_set got %h want b", v); end
        tests++; if (int_o !== 1'b1) begin fails++; $display("FAIL col_int got %0b want 1", int_o); end
        wr(CTRL, 32'h8);
        // COUNT write in a tick cycle
        wr(CMP, 32'h100);
        wr(COUNT, 32'h0);
        wr(CTRL, 32'h1);
        idle(2);
        rd(COUNT, v);
        tests++; if (v !== 32'h2) begin fails++; $display("FAIL col_count_run got %h want 2", v); end
        wr(COUNT, 32'h10);
        rd(COUNT, v);
        tests++; if (v !== 32'h10) begin fails++; $display("FAIL col_count_wr got %h want 10", v); end
        idle(1);
        rd(COUNT, v);
        tests++; if (v !== 32'h11) begin fails++; $display("FAIL col_count_after got %h want 11", v); end
        wr(CTRL, 32'h0);
        idle(3);
        rd(COUNT, v);
        tests++; if (v !== 32'h12) begin fails++; $display("FAIL col_freeze got %h want 12", v); end
    endtask

    task automatic test_bus_hygiene;
        logic [31:0] v;
        rd(RSVD, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL bus_rsvd_rd got %h want 0", v); end
        wr(RSVD, 32'hFFFF_FFFF);
        rd(CTRL, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL bus_rsvd_ctrl got %h want 0", v); end
        rd(COUNT, v);
        tests++; if (v !== 32'h12) begin fails++; $display("FAIL bus_rsvd_count got %h want 12", v); end
        rd(CMP, v);
        tests++; if (v !== 32'h100) begin fails++; $display("FAIL bus_rsvd_cmp got %h want 100", v); end
        rd(32'h14, v);
        tests++; if (v !== 32'h12) begin fails++; $display("FAIL bus_alias got %h want 12", v); end
        addr_i = COUNT;
        #1;
        tests++; if (data_o !== 32'h0) begin fails++; $display("FAIL bus_noreq got %h want 0", data_o); end
        req_i = 1'b1;
        we_i  = 1'b1;
        addr_i = CMP;
        data_i = 32'h100;
        #1;
        tests++; if (data_o !== 32'h0) begin fails++; $display("FAIL bus_we got %h want 0", data_o); end
        req_i = 1'b0;
        we_i  = 1'b0;
        addr_i = '0;
        data_i = '0;
        @(negedge clk);
        // all-ones CTRL write landing in a match tick: hardware set keeps PEND
        wr(CMP, 32'h5);
        wr(COUNT, 32'h5);
        wr(CTRL, 32'h1);
        wr(CTRL, 32'hFFFF_FFFF);
        rd(CTRL, v);
        tests++; if (v !== 32'h0000_FF0F) begin fails++; $display("FAIL bus_ctrl_ones got %h want ff0f", v); end
        tests++; if (int_o !== 1'b1) begin fails++; $display("FAIL bus_ones_int got %0b want 1", int_o); end
        rd(COUNT, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL bus_ones_count got %h want 0", v); end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b0;
        req_i  = 1'b0;
        we_i   = 1'b0;
        addr_i = '0;
        data_i = '0;
        test_reset();
        test_periodic();
        test_prescaler();
        test_oneshot();
        test_collisions();
        test_bus_hygiene();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
